jtag_tap_ctrl: RTL and testbench

IEEE 1149.1-style TAP controller that drives the boundary-scan register chain. It oversamples the external TCK/TMS/TDI pins in the ICLK domain and runs the 16-state TAP state machine. It also holds the instruction register and bypass/IDCODE registers. From these it produces the `mode`, `shift_dr`, `clk_dr` and `update_dr` controls consumed by the `bsr` chain, and muxes the chain's serial output onto TDO.

---
 rtl/jtag_tap_ctrl.sv | 155 +++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// TAP controller for the boundary-scan chain. It oversamples the TCK/TMS/TDI pins on ICLK and
// runs the 16-state TAP FSM. It also holds the IR, IDCODE and BYPASS registers and drives the
// BSR controls.
module jtag_tap_ctrl #(
    parameter int unsigned IR_WIDTH = 4,
    parameter logic [31:0] IDCODE   = 32'h1000_0001
) (
    input  logic                ICLK,
    input  logic                reset,
    input  logic                tck,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic                bsr_si,
    input  logic                bsr_so,
    output logic                mode,
    output logic                shift_dr,
    output logic                clk_dr,
    output logic                update_dr,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir
);

    typedef enum logic [3:0] {
        StTlr     = 4'hF, StRti     = 4'hC, StSelDr   = 4'h7, StCapDr   = 4'h6,
        StShDr    = 4'h2, StEx1Dr   = 4'h1, StPauseDr = 4'h3, StEx2Dr   = 4'h0,
        StUpdDr   = 4'h5, StSelIr   = 4'h4, StCapIr   = 4'hE, StShIr    = 4'hA,
        StEx1Ir   = 4'h9, StPauseIr = 4'hB, StEx2Ir   = 4'h8, StUpdIr   = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] InsExtest = '0;
    localparam logic [IR_WIDTH-1:0] InsSample = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] InsIdcode = IR_WIDTH'(2);

    tap_state_e          state_q, state_d;
    logic [1:0]          tck_sync_q, tms_sync_q, tdi_sync_q;
    logic                tck_prev_q;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d, ir_q, ir_d;
    logic [31:0]         id_sr_q, id_sr_d;
    logic                byp_q, byp_d;
    logic                tdo_q, tdo_d, tdo_en_q, tdo_en_d, mode_q, mode_d;

    logic tck_s, tms_s, tdi_s, tck_rise, tck_fall;
    logic bsr_sel, id_sel, in_shift;

    assign tck_s    = tck_sync_q[1];
    assign tms_s    = tms_sync_q[1];
    assign tdi_s    = tdi_sync_q[1];
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    // Undefined instruction codes fall through to the bypass register.
    assign bsr_sel  = (ir_q == InsExtest) || (ir_q == InsSample);
    assign id_sel   = (ir_q == InsIdcode);
    assign in_shift = (state_q == StShDr) || (state_q == StShIr);

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            unique case (state_q)
                StTlr:     state_d = tms_s ? StTlr     : StRti;
                StRti:     state_d = tms_s ? StSelDr   : StRti;
                StSelDr:   state_d = tms_s ? StSelIr   : StCapDr;
                StCapDr:   state_d = tms_s ? StEx1Dr   : StShDr;
                StShDr:    state_d = tms_s ? StEx1Dr   : StShDr;
                StEx1Dr:   state_d = tms_s ? StUpdDr   : StPauseDr;
                StPauseDr: state_d = tms_s ? StEx2Dr   : StPauseDr;
                StEx2Dr:   state_d = tms_s ? StUpdDr   : StShDr;
                StUpdDr:   state_d = tms_s ? StSelDr   : StRti;
                StSelIr:   state_d = tms_s ? StTlr     : StCapIr;
                StCapIr:   state_d = tms_s ? StEx1Ir   : StShIr;
                StShIr:    state_d = tms_s ? StEx1Ir   : StShIr;
                StEx1Ir:   state_d = tms_s ? StUpdIr   : StPauseIr;
                StPauseIr: state_d = tms_s ? StEx2Ir   : StPauseIr;
                StEx2Ir:   state_d = tms_s ? StUpdIr   : StShIr;
                StUpdIr:   state_d = tms_s ? StSelDr   : StRti;
            endcase
        end
    end

    always_comb begin
        ir_sr_d  = ir_sr_q;
        id_sr_d  = id_sr_q;
        byp_d    = byp_q;
        ir_d     = ir_q;
        tdo_d    = tdo_q;
        tdo_en_d = tdo_en_q;
        mode_d   = (ir_q == InsExtest);
        if (tck_rise) begin
            if (state_q == StCapIr) ir_sr_d = IR_WIDTH'(1);
            if (state_q == StShIr)  ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
            if (state_q == StCapDr) begin
                id_sr_d = IDCODE;
                byp_d   = 1'b0;
            end
            if (state_q == StShDr) begin
                if (id_sel)        id_sr_d = {tdi_s, id_sr_q[31:1]};
                else if (!bsr_sel) byp_d   = tdi_s;
            end
        end
        if (tck_fall) begin
            if (state_q == StUpdIr) ir_d = ir_sr_q;
            tdo_en_d = in_shift;
            if (state_q == StShIr) begin
                tdo_d = ir_sr_q[0];
            end else if (state_q == StShDr) begin
                tdo_d = bsr_sel ? bsr_so : (id_sel ? id_sr_q[0] : byp_q);
            end
        end
        if (state_q == StTlr) ir_d = InsIdcode;
    end

    always_ff @(posedge ICLK) begin
        if (reset) begin
            state_q    <= StTlr;
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_prev_q <= 1'b0;
            ir_sr_q    <= '0;
            id_sr_q    <= '0;
            byp_q      <= 1'b0;
            ir_q       <= InsIdcode;
            tdo_q      <= 1'b0;
            tdo_en_q   <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tck_sync_q <= {tck_sync_q[0], tck};
            tms_sync_q <= {tms_sync_q[0], tms};
            tdi_sync_q <= {tdi_sync_q[0], tdi};
            tck_prev_q <= tck_s;
            ir_sr_q    <= ir_sr_d;
            id_sr_q    <= id_sr_d;
            byp_q      <= byp_d;
            ir_q       <= ir_d;
            tdo_q      <= tdo_d;
            tdo_en_q   <= tdo_en_d;
            mode_q     <= mode_d;
        end
    end

    // Strobes decode the pre-transition state so shift_dr is stable around every clk_dr.
    assign clk_dr    = tck_rise & bsr_sel & ((state_q == StCapDr) || (state_q == StShDr));
    assign update_dr = tck_fall & bsr_sel & (state_q == StUpdDr);
    assign shift_dr  = bsr_sel & (state_q == StShDr);
    assign tap_state = state_q;
    assign ir        = ir_q;
    assign mode      = mode_q;
    assign tdo       = tdo_q;
    assign tdo_en    = tdo_en_q;
    assign bsr_si    = tdi_s;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomized bench for jtag_tap_ctrl: a TCK-cycle-level TAP model plus directed scans.
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IdcodeVal = 32'h1000_0001;

    logic       ICLK = 1'b0;
    logic       reset = 1'b1;
    logic       tck = 1'b0, tms = 1'b1, tdi = 1'b0, bsr_so = 1'b0;
    logic       tdo, tdo_en, bsr_si, mode, shift_dr, clk_dr, update_dr;
    logic [3:0] tap_state, ir;

    jtag_tap_ctrl dut (
        .ICLK      (ICLK),
        .reset     (reset),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_en    (tdo_en),
        .bsr_si    (bsr_si),
        .bsr_so    (bsr_so),
        .mode      (mode),
        .shift_dr  (shift_dr),
        .clk_dr    (clk_dr),
        .update_dr (update_dr),
        .tap_state (tap_state),
        .ir        (ir)
    );

    always #5 ICLK = ~ICLK;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor, sampled mid-cycle.
    int   clk_cnt = 0, upd_cnt = 0, viol = 0;
    logic sd_prev = 1'b0;
    always @(negedge ICLK) begin
        if (clk_dr === 1'b1) begin
            clk_cnt++;
            if (shift_dr !== sd_prev) viol++;
        end
        if (update_dr === 1'b1) upd_cnt++;
        if (clk_dr === 1'b1 && update_dr === 1'b1) viol++;
        sd_prev = shift_dr;
    end

    // Reference model: TAP graph as a lookup table of the spec's state codes.
    int          nxt0[16], nxt1[16];
    int          st_m;
    logic [3:0]  ir_m, ir_sr_m;
    logic [31:0] id_m;
    logic        byp_m, tdo_m, tdo_en_m, tdo_seen;

    task automatic arc(input int s, input int n0, input int n1);
        nxt0[s] = n0;
        nxt1[s] = n1;
    endtask

    task automatic model_reset();
        st_m = 15; ir_m = 4'd2; ir_sr_m = '0; id_m = '0;
        byp_m = 1'b0; tdo_m = 1'b0; tdo_en_m = 1'b0;
    endtask

    task automatic tck_cycle(input logic tms_v, input logic tdi_v);
        int   c0, u0, exp_clk, exp_upd;
        logic so_v, bs, ids;
        so_v = 1'($urandom_range(0, 1));
        tms = tms_v; tdi = tdi_v; bsr_so = so_v;
        repeat (4) @(posedge ICLK);
        #1;
        tdo_seen = tdo;
        c0 = clk_cnt;
        tck = 1'b1;
        repeat ($urandom_range(5, 7)) @(posedge ICLK);
        #1;
        bs  = (ir_m == 4'd0) || (ir_m == 4'd1);
        ids = (ir_m == 4'd2);
        exp_clk = (bs && (st_m == 6 || st_m == 2)) ? 1 : 0;
        if (st_m == 14) ir_sr_m = 4'b0001;
        else if (st_m == 10) ir_sr_m = {tdi_v, ir_sr_m[3:1]};
        if (st_m == 6) begin
            id_m = IdcodeVal; byp_m = 1'b0;
        end else if (st_m == 2) begin
            if (ids) id_m = {tdi_v, id_m[31:1]};
            else if (!bs) byp_m = tdi_v;
        end
        st_m = tms_v ? nxt1[st_m] : nxt0[st_m];
        if (st_m == 15) ir_m = 4'd2;
        check_eq("tap_state", 32'(tap_state), 32'(st_m));
        check_eq("shift_dr", 32'(shift_dr), 32'(bs && st_m == 2));
        check_eq("clk_dr_pulses", 32'(clk_cnt - c0), 32'(exp_clk));
        u0 = upd_cnt;
        tck = 1'b0;
        repeat ($urandom_range(5, 7)) @(posedge ICLK);
        #1;
        bs  = (ir_m == 4'd0) || (ir_m == 4'd1);
        ids = (ir_m == 4'd2);
        exp_upd = (bs && st_m == 5) ? 1 : 0;
        if (st_m == 13) ir_m = ir_sr_m;
        if (st_m == 10) tdo_m = ir_sr_m[0];
        else if (st_m == 2) tdo_m = bs ? so_v : (ids ? id_m[0] : byp_m);
        tdo_en_m = (st_m == 2) || (st_m == 10);
        check_eq("ir", 32'(ir), 32'(ir_m));
        check_eq("mode", 32'(mode), 32'(ir_m == 4'd0));
        check_eq("tdo", 32'(tdo), 32'(tdo_m));
        check_eq("tdo_en", 32'(tdo_en), 32'(tdo_en_m));
        check_eq("update_dr_pulses", 32'(upd_cnt - u0), 32'(exp_upd));
        check_eq("bsr_si", 32'(bsr_si), 32'(tdi_v));
    endtask

    task automatic tms_walk(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) tck_cycle(bits[i], 1'($urandom_range(0, 1)));
    endtask

    task automatic shift_bits(input logic [31:0] data, input int n, input logic exit_last,
                              output logic [31:0] seen);
        seen = '0;
        for (int i = 0; i < n; i++) begin
            tck_cycle(exit_last && (i == n - 1), data[i]);
            seen[i] = tdo_seen;
        end
    endtask

    task automatic do_reset();
        int c0, u0;
        c0 = clk_cnt; u0 = upd_cnt;
        reset = 1'b1;
        @(posedge ICLK);
        #1;
        check_eq("rst_tap_state", 32'(tap_state), 32'hF);
        check_eq("rst_ir", 32'(ir), 32'h2);
        check_eq("rst_mode", 32'(mode), 32'h0);
        check_eq("rst_shift_dr", 32'(shift_dr), 32'h0);
        check_eq("rst_clk_dr", 32'(clk_dr), 32'h0);
        check_eq("rst_update_dr", 32'(update_dr), 32'h0);
        check_eq("rst_tdo", 32'(tdo), 32'h0);
        check_eq("rst_tdo_en", 32'(tdo_en), 32'h0);
        reset = 1'b0;
        model_reset();
        check_eq("rst_no_update", 32'(upd_cnt - u0), 32'h0);
        check_eq("rst_no_clk_dr", 32'(clk_cnt - c0), 32'h0);
    endtask

    initial begin
        logic [31:0] seen;
        int          c0, u0;
        arc(15, 12, 15); arc(12, 12, 7);  arc(7, 6, 4);   arc(6, 2, 1);
        arc(2, 2, 1);    arc(1, 3, 5);    arc(3, 3, 0);   arc(0, 2, 5);
        arc(5, 12, 7);   arc(4, 14, 15);  arc(14, 10, 9); arc(10, 10, 9);
        arc(9, 11, 13);  arc(11, 11, 8);  arc(8, 10, 13); arc(13, 12, 7);
        model_reset();
        repeat (3) @(posedge ICLK);
        #1;
        do_reset();

        // IDCODE readout
        tms_walk(16'h001F, 5);
        check_eq("tlr_state", 32'(tap_state), 32'hF);
        check_eq("tlr_ir", 32'(ir), 32'h2);
        tms_walk(16'b0010, 4);
        shift_bits(32'($urandom), 32, 1'b0, seen);
        check_eq("idcode_word", seen, IdcodeVal);
        tms_walk(16'b011, 3);

        // IR scan loading EXTEST
        tms_walk(16'h001F, 5);
        tms_walk(16'b00110, 5);
        shift_bits(32'h0, 4, 1'b1, seen);
        check_eq("ir_capture", seen, 32'h1);
        tms_walk(16'b01, 2);
        check_eq("extest_ir", 32'(ir), 32'h0);
        check_eq("extest_mode", 32'(mode), 32'h1);

        // EXTEST DR scan
        c0 = clk_cnt; u0 = upd_cnt;
        tms_walk(16'b001, 3);
        shift_bits(32'($urandom), 8, 1'b1, seen);
        tms_walk(16'b01, 2);
        check_eq("extest_clk_dr", 32'(clk_cnt - c0), 32'd9);
        check_eq("extest_update", 32'(upd_cnt - u0), 32'd1);

        // BYPASS
        tms_walk(16'b0011, 4);
        shift_bits(32'hF, 4, 1'b1, seen);
        tms_walk(16'b01, 2);
        check_eq("bypass_ir", 32'(ir), 32'hF);
        c0 = clk_cnt; u0 = upd_cnt;
        tms_walk(16'b001, 3);
        shift_bits(32'hA5, 8, 1'b1, seen);
        tms_walk(16'b01, 2);
        check_eq("bypass_data", seen, 32'h4A);
        check_eq("bypass_clk_dr", 32'(clk_cnt - c0), 32'd0);
        check_eq("bypass_update", 32'(upd_cnt - u0), 32'd0);

        // Reset in the middle of an EXTEST DR scan
        tms_walk(16'b0011, 4);
        shift_bits(32'h0, 4, 1'b1, seen);
        tms_walk(16'b01, 2);
        tms_walk(16'b001, 3);
        shift_bits(32'($urandom), 3, 1'b0, seen);
        do_reset();

        // Escape from Pause-IR
        tms_walk(16'b00110, 5);
        tms_walk(16'b01, 2);
        check_eq("pause_ir_state", 32'(tap_state), 32'hB);
        tms_walk(16'h001F, 5);
        check_eq("escape_state", 32'(tap_state), 32'hF);
        check_eq("escape_ir", 32'(ir), 32'h2);

        // Random walk
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            else tck_cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        check_eq("strobe_overlap", 32'(viol), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
